// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
// Holds the FSM state encoding and BCD helpers.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [3:0] BCD_ZERO = 4'd0;
   localparam logic [3:0] BCD_NINE = 4'd9;

   localparam logic [3:0] SEC_TENS_WRAP_DEF = 4'd5;

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a borrow-chained decrementer.
// Wraps to wrap_value and borrows when a zero digit is asked to borrow.
module bcd_digit_dec
   import timer_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       borrow_in,
   input  logic [3:0] wrap_value,
   output logic [3:0] digit_next,
   output logic       borrow_out
);

   // Decrement this digit when the lower digit borrows from it
   always_comb begin
      digit_next = digit;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit == BCD_ZERO) begin
            digit_next = wrap_value;
            borrow_out = 1'b1;
         end else begin
            digit_next = digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/timer_countdown.sv
// Microwave-style mm:ss countdown timer with keypad entry.
// IDLE/RUN/PAUSE/DONE FSM driving a four-digit BCD decrementer.
module timer_countdown
   import timer_pkg::*;
#(
   parameter logic [3:0] SEC_TENS_WRAP = SEC_TENS_WRAP_DEF
) (
   input  logic       clock,
   input  logic       clear,
   input  logic [3:0] digit_in,
   input  logic       digit_valid,
   input  logic       start,
   input  logic       stop,
   input  logic       cancel,
   input  logic       tick,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       mag_on,
   output logic       done
);

   state_e     state_q, state_d;
   logic [3:0] mt_q, mo_q, st_q, so_q;
   logic [3:0] mt_d, mo_d, st_d, so_d;

   logic [3:0] mt_dec, mo_dec, st_dec, so_dec;
   logic       b_so, b_st, b_mo, b_mt;
   logic       is_zero, dec_zero;

   bcd_digit_dec u_so (
      .digit      (so_q),
      .borrow_in  (1'b1),
      .wrap_value (BCD_NINE),
      .digit_next (so_dec),
      .borrow_out (b_so)
   );

   bcd_digit_dec u_st (
      .digit      (st_q),
      .borrow_in  (b_so),
      .wrap_value (SEC_TENS_WRAP),
      .digit_next (st_dec),
      .borrow_out (b_st)
   );

   bcd_digit_dec u_mo (
      .digit      (mo_q),
      .borrow_in  (b_st),
      .wrap_value (BCD_NINE),
      .digit_next (mo_dec),
      .borrow_out (b_mo)
   );

   bcd_digit_dec u_mt (
      .digit      (mt_q),
      .borrow_in  (b_mo),
      .wrap_value (BCD_NINE),
      .digit_next (mt_dec),
      .borrow_out (b_mt)
   );

   // A borrow out of the top digit means 00:00; never apply it
   assign is_zero  = (mt_q == BCD_ZERO) && (mo_q == BCD_ZERO) &&
                     (st_q == BCD_ZERO) && (so_q == BCD_ZERO);
   assign dec_zero = (mt_dec == BCD_ZERO) && (mo_dec == BCD_ZERO) &&
                     (st_dec == BCD_ZERO) && (so_dec == BCD_ZERO);

   // Next-state and next-digit selection, priorities per state
   always_comb begin
      state_d = state_q;
      mt_d    = mt_q;
      mo_d    = mo_q;
      st_d    = st_q;
      so_d    = so_q;
      unique case (state_q)
         IDLE: begin
            if (cancel) begin
               mt_d = BCD_ZERO;
               mo_d = BCD_ZERO;
               st_d = BCD_ZERO;
               so_d = BCD_ZERO;
            end else if (start && !is_zero) begin
               state_d = RUN;
            end else if (digit_valid && digit_in <= BCD_NINE) begin
               mt_d = mo_q;
               mo_d = st_q;
               st_d = so_q;
               so_d = digit_in;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = PAUSE;
            end else if (tick && !b_mt) begin
               mt_d = mt_dec;
               mo_d = mo_dec;
               st_d = st_dec;
               so_d = so_dec;
               if (dec_zero) state_d = DONE;
            end
         end
         PAUSE: begin
            if (cancel) begin
               state_d = IDLE;
               mt_d    = BCD_ZERO;
               mo_d    = BCD_ZERO;
               st_d    = BCD_ZERO;
               so_d    = BCD_ZERO;
            end else if (start) begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and digit registers with synchronous clear
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= IDLE;
         mt_q    <= BCD_ZERO;
         mo_q    <= BCD_ZERO;
         st_q    <= BCD_ZERO;
         so_q    <= BCD_ZERO;
      end else begin
         state_q <= state_d;
         mt_q    <= mt_d;
         mo_q    <= mo_d;
         st_q    <= st_d;
         so_q    <= so_d;
      end
   end

   assign min_tens = mt_q;
   assign min_ones = mo_q;
   assign sec_tens = st_q;
   assign sec_ones = so_q;
   assign mag_on   = (state_q == RUN);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_timer_countdown.sv
// Scenario bench for timer_countdown.
// Expected display/status words queue up with stimulus, checked per task.
module tb_timer_countdown;

   logic       clock = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] digit_in = 4'd0;
   logic       digit_valid = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       cancel = 1'b0;
   logic       tick = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       mag_on, done;

   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] CLR  = 6'b100000;
   localparam logic [5:0] DV   = 6'b010000;
   localparam logic [5:0] STA  = 6'b001000;
   localparam logic [5:0] STP  = 6'b000100;
   localparam logic [5:0] CAN  = 6'b000010;
   localparam logic [5:0] TCK  = 6'b000001;

   int errors = 0;
   int checks = 0;

   logic [17:0] exp_q[$];
   logic [17:0] obs_q[$];
   string       nm_q[$];

   timer_countdown #(.SEC_TENS_WRAP(4'd5)) dut (
      .clock       (clock),
      .clear       (clear),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .start       (start),
      .stop        (stop),
      .cancel      (cancel),
      .tick        (tick),
      .min_tens    (min_tens),
      .min_ones    (min_ones),
      .sec_tens    (sec_tens),
      .sec_ones    (sec_ones),
      .mag_on      (mag_on),
      .done        (done)
   );

   always #5 clock = ~clock;

   function automatic logic [17:0] ex(input logic [15:0] t,
                                      input logic mg, input logic dn);
      return {t, mg, dn};
   endfunction

   // One clock of stimulus; optionally queue expectation and observation
   task automatic drive(input logic [5:0] m, input int d, input bit chk,
                        input logic [17:0] e, input string nm);
      clear       = m[5];
      digit_valid = m[4];
      start       = m[3];
      stop        = m[2];
      cancel      = m[1];
      tick        = m[0];
      digit_in    = 4'(d);
      if (chk) begin
         exp_q.push_back(e);
         nm_q.push_back(nm);
      end
      @(posedge clock);
      #1;
      if (chk)
         obs_q.push_back({min_tens, min_ones, sec_tens, sec_ones,
                          mag_on, done});
      clear       = 1'b0;
      digit_valid = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
      cancel      = 1'b0;
      tick        = 1'b0;
   endtask

   task automatic key(input int d);
      drive(DV, d, 1'b0, '0, "");
   endtask

   task automatic go(input logic [5:0] m);
      drive(m, 0, 1'b0, '0, "");
   endtask

   task automatic test_reset();
      logic [17:0] e, o;
      string n;
      drive(CLR | STA | TCK | DV, 3, 1'b1, ex(16'h0000, 0, 0), "reset");
      drive(NONE, 0, 1'b1, ex(16'h0000, 0, 0), "reset_hold");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got %h mag=%b done=%b want %h mag=%b done=%b",
                     n, o[17:2], o[1], o[0], e[17:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_entry();
      logic [17:0] e, o;
      string n;
      drive(DV, 1, 1'b1, ex(16'h0001, 0, 0), "entry_1");
      drive(DV, 2, 1'b1, ex(16'h0012, 0, 0), "entry_2");
      drive(DV, 3, 1'b1, ex(16'h0123, 0, 0), "entry_3");
      drive(DV, 0, 1'b1, ex(16'h1230, 0, 0), "entry_4");
      drive(DV, 12, 1'b1, ex(16'h1230, 0, 0), "bad_digit");
      drive(TCK, 0, 1'b1, ex(16'h1230, 0, 0), "tick_idle");
      drive(CAN, 0, 1'b1, ex(16'h0000, 0, 0), "cancel_idle");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got %h mag=%b done=%b want %h mag=%b done=%b",
                     n, o[17:2], o[1], o[0], e[17:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_borrow();
      logic [17:0] e, o;
      string n;
      key(1); key(0); key(0); key(0);
      drive(STA, 0, 1'b1, ex(16'h1000, 1, 0), "start_1000");
      drive(TCK, 0, 1'b1, ex(16'h0959, 1, 0), "borrow_1000");
      drive(STP, 0, 1'b1, ex(16'h0959, 0, 0), "stop_0959");
      drive(CAN, 0, 1'b1, ex(16'h0000, 0, 0), "cancel_0959");
      key(1); key(0); key(0);
      drive(STA, 0, 1'b1, ex(16'h0100, 1, 0), "start_0100");
      drive(TCK, 0, 1'b1, ex(16'h0059, 1, 0), "borrow_0100");
      go(STP); go(CAN);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got %h mag=%b done=%b want %h mag=%b done=%b",
                     n, o[17:2], o[1], o[0], e[17:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_done();
      logic [17:0] e, o;
      string n;
      key(2);
      drive(STA, 0, 1'b1, ex(16'h0002, 1, 0), "start_0002");
      drive(TCK, 0, 1'b1, ex(16'h0001, 1, 0), "tick_0001");
      drive(TCK, 0, 1'b1, ex(16'h0000, 0, 1), "done_pulse");
      drive(DV | STA, 7, 1'b1, ex(16'h0000, 0, 0), "done_ignores");
      drive(DV, 4, 1'b1, ex(16'h0004, 0, 0), "idle_after_done");
      go(CAN);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got %h mag=%b done=%b want %h mag=%b done=%b",
                     n, o[17:2], o[1], o[0], e[17:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_pause();
      logic [17:0] e, o;
      string n;
      key(1); key(0);
      drive(STA, 0, 1'b1, ex(16'h0010, 1, 0), "start_0010");
      drive(STP | TCK | STA, 0, 1'b1, ex(16'h0010, 0, 0), "stop_beats_tick");
      drive(TCK, 0, 1'b1, ex(16'h0010, 0, 0), "tick_pause");
      drive(DV, 5, 1'b1, ex(16'h0010, 0, 0), "digit_pause");
      drive(STA, 0, 1'b1, ex(16'h0010, 1, 0), "resume");
      drive(TCK, 0, 1'b1, ex(16'h0009, 1, 0), "tick_0009");
      drive(CAN, 0, 1'b1, ex(16'h0009, 1, 0), "cancel_run");
      drive(STP, 0, 1'b1, ex(16'h0009, 0, 0), "stop_0009");
      drive(CAN | STA, 0, 1'b1, ex(16'h0000, 0, 0), "cancel_pause");
      drive(DV, 3, 1'b1, ex(16'h0003, 0, 0), "idle_after_cancel");
      go(CAN);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got %h mag=%b done=%b want %h mag=%b done=%b",
                     n, o[17:2], o[1], o[0], e[17:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_edge();
      logic [17:0] e, o;
      string n;
      drive(STA, 0, 1'b1, ex(16'h0000, 0, 0), "start_zero");
      drive(TCK, 0, 1'b1, ex(16'h0000, 0, 0), "zero_stays");
      key(9); key(0);
      drive(STA, 0, 1'b1, ex(16'h0090, 1, 0), "start_0090");
      drive(TCK, 0, 1'b1, ex(16'h0089, 1, 0), "sec_90");
      drive(TCK, 0, 1'b1, ex(16'h0088, 1, 0), "sec_89");
      go(STP); go(CAN);
      key(5); key(0); key(0);
      drive(STA, 0, 1'b1, ex(16'h0500, 1, 0), "start_0500");
      drive(TCK, 0, 1'b1, ex(16'h0459, 1, 0), "tick_0459");
      drive(CLR | TCK, 0, 1'b1, ex(16'h0000, 0, 0), "clear_mid_run");
      drive(TCK | STA, 0, 1'b1, ex(16'h0000, 0, 0), "clear_idle");
      key(7);
      drive(CAN | STA | DV, 1, 1'b1, ex(16'h0000, 0, 0), "cancel_beats");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got %h mag=%b done=%b want %h mag=%b done=%b",
                     n, o[17:2], o[1], o[0], e[17:2], e[1], e[0]);
         end
      end
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_entry();
      test_borrow();
      test_done();
      test_pause();
      test_edge();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/timer_countdown.md
TIMER_COUNTDOWN -- requirements
Module: timer_countdown

Interface
REQ-001 SHALL have parameter SEC_TENS_WRAP, default 5, the seconds-tens value loaded on a minute borrow.
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port digit_in  input  4  BCD digit from the keypad encoder.
REQ-005 SHALL have port digit_valid  input  1  one-cycle strobe qualifying digit_in.
REQ-006 SHALL have port start  input  1  one-cycle start/resume strobe; the delayed start pulse from the start-delay counter.
REQ-007 SHALL have port stop  input  1  one-cycle pause strobe (stop key or door open).
REQ-008 SHALL have port cancel  input  1  one-cycle strobe that zeroes the time when not running.
REQ-009 SHALL have port tick  input  1  one-cycle 1 Hz enable.
REQ-010 SHALL have ports min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD time mm:ss.
REQ-011 SHALL have port mag_on  output  1  high exactly while state is RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the countdown reaches 00:00.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-014 IDLE: digit_valid with digit_in <= 9 SHALL shift the digits left (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit_in), visible the next cycle.
REQ-015 digit_in > 9 SHALL be ignored; digit_valid outside IDLE SHALL be ignored.
REQ-016 IDLE + start with time nonzero -> RUN; with time 00:00 start SHALL be ignored.
REQ-017 RUN + tick -> decrement by one second, visible the cycle after the tick.
REQ-018 Decrement rules:
- sec_ones>0: sec_ones-1.
- sec_ones=0 and sec_tens>0: sec_tens-1, sec_ones=9.
- seconds 00 with minutes nonzero: sec_tens=SEC_TENS_WRAP, sec_ones=9, and minutes decrement with the same BCD borrow (min_ones 0 -> 9, min_tens-1).
REQ-019 Entered seconds above 59 (e.g. 0:90) SHALL count down linearly through 89, 88, ... without normalisation.
REQ-020 RUN: a decrement that yields 00:00 SHALL move the block to DONE on the same edge; done SHALL be high for exactly that one DONE cycle; mag_on SHALL be low from that cycle.
REQ-021 DONE SHALL return to IDLE unconditionally on the next cycle; all inputs in DONE SHALL be ignored.
REQ-022 RUN + stop -> PAUSE, with time held.
REQ-023 PAUSE + start -> RUN.
REQ-024 PAUSE + cancel -> IDLE with all digits 0.
REQ-025 IDLE + cancel SHALL zero all digits.
REQ-026 cancel in RUN SHALL be ignored.
REQ-027 Simultaneous events:
- stop beats tick and start: no decrement, go to PAUSE.
- cancel beats start and digit_valid.
- tick outside RUN is ignored.
REQ-028 Minutes at 00 with seconds 00 SHALL never borrow; the block SHALL not wrap below 00:00.

Reset
REQ-029 clear high at a rising edge SHALL force IDLE, all digits 0, mag_on 0, done 0, regardless of state or any other input, including mid-RUN.
REQ-030 There SHALL be no asynchronous reset path.

Structure
REQ-031 Package timer_pkg SHALL hold:
- the state enumeration (IDLE, RUN, PAUSE, DONE, 2-bit encoding);
- BCD constants BCD_NINE and BCD_ZERO;
- default SEC_TENS_WRAP.
REQ-032 One sub-module bcd_digit_dec SHALL be instantiated per digit:
- inputs: digit, borrow_in, wrap_value;
- outputs: next digit, borrow_out (digit was 0 and borrow_in was 1).

Verification
REQ-033 Entry: clear, then digits 1,2,3,0 -> display 12:30. A digit_in=12 strobe -> unchanged.
REQ-034 Borrow chain: load 10:00, start, 1 tick -> 09:59, mag_on=1. Load 01:00, 1 tick -> 00:59.
REQ-035 Completion: load 00:02, start, 2 ticks -> done pulse of 1 cycle on the 2nd decrement, mag_on=0, IDLE next cycle.
REQ-036 Pause/resume:
- 00:10, RUN, tick and stop in the same cycle -> 00:10 held in PAUSE;
- start, tick -> 00:09;
- stop, cancel -> IDLE 00:00.
REQ-037 Edge cases:
- start at 00:00 -> stays IDLE;
- load 0:90, run 1 tick -> 00:89;
- clear mid-RUN at 05:00 -> IDLE 00:00, mag_on=0 next cycle.
